pipe_hazard_ctrl: RTL and testbench

//  Stall/flush controller that drives the ID/EXE pipeline register from the execute side. Tracks in-flight

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   NUM_REGS   : architectural register count, one scoreboard bit per register
//   REG_PC     : register index of the PC; loads to it are handled as branches
//   LD_CNT_W   : width of the outstanding-load counter (covers MAX_LOADS up to 7)
//   hz_state_e : flush sequencer states
package cm0_pipe_pkg;

    localparam int         NUM_REGS = 16;
    localparam logic [3:0] REG_PC   = 4'd15;
    localparam int         LD_CNT_W = 3;

    typedef enum logic [0:0] {
        HZ_IDLE  = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute/writeback side-band bundle for the hazard controller.
//   master : pipeline datapath (drives decode/exe/wb info, consumes hold/flush/bubble)
//   slave  : hazard controller
interface pipe_hazard_ctrl_if;

    logic                                id_valid;
    logic [3:0]                          id_addr_n;
    logic [3:0]                          id_addr_m;
    logic [3:0]                          id_addr_t;
    logic                                id_use_n;
    logic                                id_use_m;
    logic                                id_use_t;
    logic [3:0]                          id_addr_d;
    logic                                id_w_reg_en;
    logic                                id_is_load;
    logic                                exe_ready;
    logic                                exe_branch_taken;
    logic                                wb_load_done;
    logic [3:0]                          wb_addr;
    logic                                if_id_hold;
    logic                                if_id_flush;
    logic                                id_exe_hold;
    logic                                id_exe_bubble;
    logic [cm0_pipe_pkg::NUM_REGS-1:0]   sb_busy;
    logic                                ld_underflow;

    modport master (
        output id_valid, id_addr_n, id_addr_m, id_addr_t, id_use_n, id_use_m, id_use_t,
               id_addr_d, id_w_reg_en, id_is_load, exe_ready, exe_branch_taken,
               wb_load_done, wb_addr,
        input  if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble, sb_busy, ld_underflow
    );

    modport slave (
        input  id_valid, id_addr_n, id_addr_m, id_addr_t, id_use_n, id_use_m, id_use_t,
               id_addr_d, id_w_reg_en, id_is_load, exe_ready, exe_branch_taken,
               wb_load_done, wb_addr,
        output if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble, sb_busy, ld_underflow
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Load scoreboard: one busy bit per register, outstanding-load counter and a
// sticky underflow flag.
//   clk, rst      : core clock, async active-low reset
//   i_set_en/addr : a load to addr issued this cycle
//   i_clr_en/addr : a load to addr wrote back this cycle
//   o_sb_busy     : busy vector
//   o_ld_cnt      : loads in flight
//   o_underflow   : writeback seen with nothing outstanding (sticky until reset)
module hz_scoreboard
    import cm0_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [3:0]          i_set_addr,
    input  logic                i_clr_en,
    input  logic [3:0]          i_clr_addr,
    output logic [NUM_REGS-1:0] o_sb_busy,
    output logic [LD_CNT_W-1:0] o_ld_cnt,
    output logic                o_underflow
);

    logic [NUM_REGS-1:0] r_sb_busy;
    logic [LD_CNT_W-1:0] r_ld_cnt;
    logic                r_underflow;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    assign w_set_mask = i_set_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << i_set_addr) : '0;
    assign w_clr_mask = i_clr_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << i_clr_addr) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_busy   <= '0;
            r_ld_cnt    <= '0;
            r_underflow <= 1'b0;
        end else begin
            // clear first, then set, so a same-cycle set of the same bit survives
            r_sb_busy <= (r_sb_busy & ~w_clr_mask) | w_set_mask;
            case ({i_set_en, i_clr_en})
                2'b10: r_ld_cnt <= r_ld_cnt + 1'b1;
                2'b01: begin
                    if (r_ld_cnt == '0) r_underflow <= 1'b1;
                    else                r_ld_cnt    <= r_ld_cnt - 1'b1;
                end
                2'b11: begin
                    // net count unchanged; a writeback against an empty count is still bogus
                    if (r_ld_cnt == '0) r_underflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_sb_busy   = r_sb_busy;
    assign o_ld_cnt    = r_ld_cnt;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the ID/EXE pipeline register.
// Detects load-use hazards against the load scoreboard, freezes on bus wait
// and inserts FLUSH_CYCLES bubbles after a taken branch.
//   clk, rst : core clock, async active-low reset
//   bus      : pipe_hazard_ctrl_if.slave (decode/exe/wb info in, hold/flush/bubble out)
//   perf_stall_cnt, perf_flush_cnt : present only when HAZARD_PERF_EN is defined;
//              saturating counts of hazard-stall cycles and accepted taken branches
// Parameters: FLUSH_CYCLES (1..7), MAX_LOADS (1..7)
module pipe_hazard_ctrl
    import cm0_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_LOADS    = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    // state    | meaning
    // S_IDLE   | normal issue; hazards stall, taken branch emits first bubble
    // S_FLUSH  | emitting remaining post-branch bubbles, r_flush_cnt left

    localparam logic [0:0]          S_IDLE       = HZ_IDLE;
    localparam logic [0:0]          S_FLUSH      = HZ_FLUSH;
    localparam logic [2:0]          FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [LD_CNT_W-1:0] LD_LIMIT     = LD_CNT_W'(MAX_LOADS);
    localparam bit                  FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    logic [0:0]          r_state;
    logic [2:0]          r_flush_cnt;
    logic [NUM_REGS-1:0] w_sb_busy;
    logic [LD_CNT_W-1:0] w_ld_cnt;
    logic                w_underflow;
    logic                w_in_idle;
    logic                w_hazard;
    logic                w_stall;
    logic                w_issue;
    logic                w_set_en;
    logic [3:0]          w_ctrl;

    assign w_in_idle = (r_state == S_IDLE);

    assign w_hazard = bus.id_valid &
                      ((bus.id_use_n & w_sb_busy[bus.id_addr_n]) |
                       (bus.id_use_m & w_sb_busy[bus.id_addr_m]) |
                       (bus.id_use_t & w_sb_busy[bus.id_addr_t]) |
                       (bus.id_is_load & (w_ld_cnt == LD_LIMIT)));

    assign w_stall  = w_in_idle & bus.exe_ready & ~bus.exe_branch_taken & w_hazard;
    assign w_issue  = w_in_idle & bus.exe_ready & ~bus.exe_branch_taken & ~w_hazard & bus.id_valid;
    assign w_set_en = w_issue & bus.id_is_load & bus.id_w_reg_en & (bus.id_addr_d != REG_PC);

    hz_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_set_en),
        .i_set_addr (bus.id_addr_d),
        .i_clr_en   (bus.wb_load_done),
        .i_clr_addr (bus.wb_addr),
        .o_sb_busy  (w_sb_busy),
        .o_ld_cnt   (w_ld_cnt),
        .o_underflow(w_underflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else if (bus.exe_ready) begin
            if (bus.exe_branch_taken) begin
                // a branch while already flushing restarts the bubble train
                r_state     <= FLUSH_MULTI ? S_FLUSH : S_IDLE;
                r_flush_cnt <= FLUSH_RELOAD;
            end else if (r_state == S_FLUSH) begin
                if (r_flush_cnt <= 3'd1) begin
                    r_state     <= S_IDLE;
                    r_flush_cnt <= '0;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 3'd1;
                end
            end
        end
    end

    // {if_id_hold, if_id_flush, id_exe_hold, id_exe_bubble}
    always_comb begin
        w_ctrl = 4'b0000;
        if (!bus.exe_ready)                                w_ctrl = 4'b1010;
        else if (!w_in_idle || bus.exe_branch_taken)       w_ctrl = 4'b0101;
        else if (w_hazard)                                 w_ctrl = 4'b1001;
    end

    // outputs are forced quiet while reset is asserted, independent of inputs
    assign bus.if_id_hold    = w_ctrl[3] & rst;
    assign bus.if_id_flush   = w_ctrl[2] & rst;
    assign bus.id_exe_hold   = w_ctrl[1] & rst;
    assign bus.id_exe_bubble = w_ctrl[0] & rst;
    assign bus.sb_busy       = w_sb_busy;
    assign bus.ld_underflow  = w_underflow;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (bus.exe_ready && bus.exe_branch_taken && (r_perf_flush != 32'hFFFF_FFFF))
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`else
    logic w_unused_stall;
    assign w_unused_stall = w_stall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_hazard_ctrl_if ifc();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    int          m_pstall;
    int          m_pflush;
`endif

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_LOADS(ML)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: set of busy registers, loads in flight, bubbles still owed
    logic [15:0] m_busy;
    int          m_cnt;
    logic        m_uf;
    int          m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_cnt  = 0;
        m_uf   = 1'b0;
        m_left = 0;
`ifdef HAZARD_PERF_EN
        m_pstall = 0;
        m_pflush = 0;
`endif
    endtask

    function automatic logic m_hazard();
        return ifc.id_valid && ((ifc.id_use_n && m_busy[ifc.id_addr_n]) ||
                                (ifc.id_use_m && m_busy[ifc.id_addr_m]) ||
                                (ifc.id_use_t && m_busy[ifc.id_addr_t]) ||
                                (ifc.id_is_load && m_cnt == ML));
    endfunction

    function automatic logic [3:0] m_ctrl();
        if (!rst)                                  return 4'b0000;
        if (!ifc.exe_ready)                        return 4'b1010;
        if (m_left > 0 || ifc.exe_branch_taken)    return 4'b0101;
        if (m_hazard())                            return 4'b1001;
        return 4'b0000;
    endfunction

    task automatic model_clock();
        logic issue;
        logic set;
        if (!rst) begin
            model_reset();
            return;
        end
        issue = ifc.exe_ready && !ifc.exe_branch_taken && m_left == 0 && ifc.id_valid && !m_hazard();
        set   = issue && ifc.id_is_load && ifc.id_w_reg_en && ifc.id_addr_d != 4'd15;
`ifdef HAZARD_PERF_EN
        if (ifc.exe_ready && !ifc.exe_branch_taken && m_left == 0 && m_hazard()) m_pstall++;
        if (ifc.exe_ready && ifc.exe_branch_taken) m_pflush++;
`endif
        if (ifc.wb_load_done) begin
            if (m_cnt == 0) m_uf = 1'b1;
            m_busy[ifc.wb_addr] = 1'b0;
        end
        if (set) m_busy[ifc.id_addr_d] = 1'b1;
        m_cnt = m_cnt + int'(set) - int'(ifc.wb_load_done);
        if (m_cnt < 0) m_cnt = 0;
        if (ifc.exe_ready) begin
            if (ifc.exe_branch_taken) m_left = FC - 1;
            else if (m_left > 0)      m_left--;
        end
    endtask

    // called at a falling edge with inputs already driven
    task automatic cycle(input string tag, input int exp_ctrl = -1);
        logic [3:0] obs;
        #1;
        if (!rst) model_reset();
        obs = {ifc.if_id_hold, ifc.if_id_flush, ifc.id_exe_hold, ifc.id_exe_bubble};
        chk({tag, "/ctrl"}, 32'(obs), 32'(m_ctrl()));
        if (exp_ctrl >= 0) chk({tag, "/ctrl_dir"}, 32'(obs), 32'(exp_ctrl));
        chk({tag, "/sb"}, 32'(ifc.sb_busy), 32'(m_busy));
        chk({tag, "/uf"}, 32'(ifc.ld_underflow), 32'(m_uf));
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clr_in();
        ifc.id_valid = 0; ifc.id_is_load = 0; ifc.id_w_reg_en = 0; ifc.id_addr_d = 0;
        ifc.id_use_n = 0; ifc.id_use_m = 0; ifc.id_use_t = 0;
        ifc.id_addr_n = 0; ifc.id_addr_m = 0; ifc.id_addr_t = 0;
        ifc.exe_ready = 1; ifc.exe_branch_taken = 0; ifc.wb_load_done = 0; ifc.wb_addr = 0;
    endtask

    task automatic load(input logic [3:0] d);
        clr_in();
        ifc.id_valid = 1; ifc.id_is_load = 1; ifc.id_w_reg_en = 1; ifc.id_addr_d = d;
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 7);
        return (r == 7) ? 4'd15 : 4'(r);
    endfunction

    task automatic rnd_in();
        ifc.id_valid         = ($urandom_range(0, 9) < 8);
        ifc.id_is_load       = ($urandom_range(0, 9) < 3);
        ifc.id_w_reg_en      = ($urandom_range(0, 9) < 8);
        ifc.id_addr_d        = rnd_reg();
        ifc.id_use_n         = 1'($urandom_range(0, 1));
        ifc.id_use_m         = 1'($urandom_range(0, 1));
        ifc.id_use_t         = 1'($urandom_range(0, 1));
        ifc.id_addr_n        = rnd_reg();
        ifc.id_addr_m        = rnd_reg();
        ifc.id_addr_t        = rnd_reg();
        ifc.exe_ready        = ($urandom_range(0, 99) < 85);
        ifc.exe_branch_taken = ($urandom_range(0, 9) < 1);
        ifc.wb_load_done     = ($urandom_range(0, 3) == 0);
        ifc.wb_addr          = rnd_reg();
    endtask

    initial begin
        model_reset();
        clr_in();
        @(negedge clk);

        // reset with random inputs: outputs quiet
        for (int i = 0; i < 3; i++) begin
            rnd_in();
            cycle("reset", 0);
        end
        rst = 1'b1;
        clr_in();
        ifc.id_valid = 1; ifc.id_w_reg_en = 1; ifc.id_addr_d = 4'd2;
        cycle("issue0", 0);

        // load-use on R3
        load(4'd3);
        cycle("ldr_r3", 0);
        chk("ldr_r3_busy", 32'(ifc.sb_busy), 32'h0008);
        clr_in();
        ifc.id_valid = 1; ifc.id_w_reg_en = 1; ifc.id_addr_d = 4'd5;
        ifc.id_use_n = 1; ifc.id_addr_n = 4'd3;
        for (int i = 0; i < 3; i++) cycle("lduse", 4'b1001);
        ifc.wb_load_done = 1; ifc.wb_addr = 4'd3;
        cycle("lduse_wb", 4'b1001);
        chk("lduse_sb_clear", 32'(ifc.sb_busy), 32'h0);
        ifc.wb_load_done = 0;
        cycle("lduse_go", 0);

        // taken branch: exactly FC bubbles
        clr_in();
        ifc.id_valid = 1; ifc.exe_branch_taken = 1;
        cycle("br0", 4'b0101);
        ifc.exe_branch_taken = 0;
        cycle("br1", 4'b0101);
        cycle("br2", 0);

        // bus wait inside the flush freezes the bubble count
        ifc.exe_branch_taken = 1;
        cycle("bw0", 4'b0101);
        ifc.exe_branch_taken = 0; ifc.exe_ready = 0;
        for (int i = 0; i < 3; i++) cycle("bw_hold", 4'b1010);
        ifc.exe_ready = 1;
        cycle("bw1", 4'b0101);
        cycle("bw2", 0);

        // R15 is never scoreboarded
        load(4'd15);
        cycle("ld_r15", 0);
        chk("ld_r15_sb", 32'(ifc.sb_busy), 32'h0);
        clr_in();
        ifc.id_valid = 1; ifc.id_use_n = 1; ifc.id_addr_n = 4'd15;
        cycle("use_r15", 0);

        // outstanding-load limit
        load(4'd1); cycle("ld1", 0);
        load(4'd2); cycle("ld2", 0);
        load(4'd4); cycle("ld3_stall", 4'b1001);
        cycle("ld3_stall", 4'b1001);
        ifc.wb_load_done = 1; ifc.wb_addr = 4'd1;
        cycle("ld3_wb", 4'b1001);
        ifc.wb_load_done = 0;
        cycle("ld3_go", 0);
        chk("ld3_sb", 32'(ifc.sb_busy), 32'h0014);
        clr_in();
        ifc.wb_load_done = 1; ifc.wb_addr = 4'd2; cycle("drain2", 0);
        ifc.wb_addr = 4'd4;                       cycle("drain4", 0);
        chk("drain_sb", 32'(ifc.sb_busy), 32'h0);

        // writeback with nothing outstanding
        ifc.wb_addr = 4'd7;
        cycle("uf", 0);
        chk("uf_flag", 32'(ifc.ld_underflow), 32'h1);
        // count stayed at zero: two loads issue, the third stalls
        load(4'd1); cycle("uf_ld1", 0);
        load(4'd2); cycle("uf_ld2", 0);
        load(4'd5); cycle("uf_ld3", 4'b1001);

        // randomized run, with a reset landing in the middle of a flush
        for (int i = 0; i < 500; i++) begin
            rnd_in();
            if (i == 250) begin
                ifc.exe_ready = 1; ifc.exe_branch_taken = 1;
            end
            if (i == 251) rst = 1'b0;
            if (i == 252) rst = 1'b1;
            cycle("rand");
        end

`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'(m_pstall));
        chk("perf_flush", perf_flush_cnt, 32'(m_pflush));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
